// File: rtl/simple_cache.sv
// Direct-mapped write-back/write-allocate cache (64 lines x 8 words) in front of
// an internal 8192-word dual-port memory; port B gives external memory access.
module simple_cache (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_read_en,
  input  logic        CPU_write_en,
  input  logic [31:0] CPU_addr,
  input  logic [31:0] CPU_write_din,
  output logic [31:0] CPU_read_dout,
  output logic        isCacheStall,
  input  logic        mem_b_we,
  input  logic [12:0] mem_b_addr,
  input  logic [31:0] mem_b_din,
  output logic [31:0] mem_b_dout,
  input  logic        error_we,
  input  logic [31:0] error_din,
  input  logic [31:0] error_addr
);

  localparam int LINES     = 64;
  localparam int WORDS     = 8;
  localparam int MEM_DEPTH = 8192;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [20:0] line_tag;
  logic [5:0]  line_idx;

  logic [31:0]      cache_data [LINES*WORDS];
  logic [20:0]      tag_array  [LINES];
  logic [LINES-1:0] valid_bits;
  logic [LINES-1:0] dirty_bits;

  logic [31:0] mem [MEM_DEPTH];
  logic [31:0] mem_a_dout;
  logic [31:0] mem_a_din;
  logic [12:0] mem_a_addr;
  logic        mem_a_we;

  logic [20:0] cpu_tag;
  logic [5:0]  cpu_idx;
  logic [2:0]  cpu_off;
  logic [8:0]  cpu_ptr;
  logic [8:0]  err_ptr;
  logic [8:0]  wb_ptr;
  logic [2:0]  fill_off;
  logic [8:0]  fill_ptr;
  logic        request;
  logic        hit;
  logic        write_hit;
  logic        fill_capture;
  logic        unused_bits;

  assign cpu_tag  = CPU_addr[31:11];
  assign cpu_idx  = CPU_addr[10:5];
  assign cpu_off  = CPU_addr[4:2];
  assign cpu_ptr  = {cpu_idx, cpu_off};
  assign err_ptr  = {error_addr[10:5], error_addr[4:2]};
  assign wb_ptr   = {line_idx, cnt[2:0]};
  assign fill_off = cnt[2:0] - 3'd1;
  assign fill_ptr = {line_idx, fill_off};

  assign unused_bits = ^{CPU_addr[1:0], error_addr[31:11], error_addr[1:0]};

  assign request   = CPU_read_en || CPU_write_en;
  assign hit       = request && valid_bits[cpu_idx] && (tag_array[cpu_idx] == cpu_tag);
  assign write_hit = !rst && (state == IDLE) && CPU_write_en && hit;

  // Memory reads lag their address by one cycle, so REFILL captures word k-1 at count k.
  assign fill_capture = !rst && (state == REFILL) && (cnt != 4'd0);

  assign isCacheStall  = (state != IDLE) || (request && !hit);
  assign CPU_read_dout = ((state == IDLE) && CPU_read_en && hit) ? cache_data[cpu_ptr] : 32'd0;

  // Memory word address keeps only the low tag bits that fit the 8192-word space.
  always_comb begin
    mem_a_we   = 1'b0;
    mem_a_addr = 13'd0;
    mem_a_din  = cache_data[wb_ptr];
    case (state)
      WRITEBACK: begin
        mem_a_we   = !rst;
        mem_a_addr = {tag_array[line_idx][3:0], line_idx, cnt[2:0]};
      end
      REFILL: begin
        mem_a_addr = {line_tag[3:0], line_idx, cnt[2:0]};
      end
      default: begin
        mem_a_we   = 1'b0;
        mem_a_addr = 13'd0;
      end
    endcase
  end

  // Port B is written after port A so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (mem_a_we) mem[mem_a_addr] <= mem_a_din;
    if (mem_b_we) mem[mem_b_addr] <= mem_b_din;
    mem_a_dout <= mem[mem_a_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) mem_b_dout <= 32'd0;
    else     mem_b_dout <= mem[mem_b_addr];
  end

  // Fault injection is applied last so it acts on the stored word regardless of other traffic.
  always_ff @(posedge clk) begin
    if (write_hit)    cache_data[cpu_ptr]  <= CPU_write_din;
    if (fill_capture) cache_data[fill_ptr] <= mem_a_dout;
    if (error_we)     cache_data[err_ptr]  <= cache_data[err_ptr] ^ error_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      line_tag   <= 21'd0;
      line_idx   <= 6'd0;
      valid_bits <= '0;
      dirty_bits <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hit) begin
            dirty_bits[cpu_idx] <= 1'b1;
          end else if (request && !hit) begin
            line_tag <= cpu_tag;
            line_idx <= cpu_idx;
            cnt      <= 4'd0;
            state    <= (valid_bits[cpu_idx] && dirty_bits[cpu_idx]) ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (cnt == 4'd7) begin
            dirty_bits[line_idx] <= 1'b0;
            cnt                  <= 4'd0;
            state                <= REFILL;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        REFILL: begin
          if (cnt == 4'd8) begin
            tag_array[line_idx]  <= line_tag;
            valid_bits[line_idx] <= 1'b1;
            dirty_bits[line_idx] <= 1'b0;
            cnt                  <= 4'd0;
            state                <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_cache.sv
// Randomised and directed checks of simple_cache against a transaction-level
// cache/memory model that predicts stall lengths and read data.
module tb_simple_cache;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        CPU_read_en = 1'b0;
  logic        CPU_write_en = 1'b0;
  logic [31:0] CPU_addr = 32'd0;
  logic [31:0] CPU_write_din = 32'd0;
  logic [31:0] CPU_read_dout;
  logic        isCacheStall;
  logic        mem_b_we = 1'b0;
  logic [12:0] mem_b_addr = 13'd0;
  logic [31:0] mem_b_din = 32'd0;
  logic [31:0] mem_b_dout;
  logic        error_we = 1'b0;
  logic [31:0] error_din = 32'd0;
  logic [31:0] error_addr = 32'd0;

  simple_cache dut (
    .clk(clk), .rst(rst),
    .CPU_read_en(CPU_read_en), .CPU_write_en(CPU_write_en),
    .CPU_addr(CPU_addr), .CPU_write_din(CPU_write_din),
    .CPU_read_dout(CPU_read_dout), .isCacheStall(isCacheStall),
    .mem_b_we(mem_b_we), .mem_b_addr(mem_b_addr),
    .mem_b_din(mem_b_din), .mem_b_dout(mem_b_dout),
    .error_we(error_we), .error_din(error_din), .error_addr(error_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: main memory plus what each cache line holds.
  logic [31:0] mem_m   [8192];
  logic [31:0] line_m  [64][8];
  int          tag_m   [64];
  bit          valid_m [64];
  bit          dirty_m [64];

  function automatic logic [31:0] mkAddr(int tag, int idx, int off);
    return 32'((tag << 11) | (idx << 5) | (off << 2));
  endfunction

  function automatic int wordOf(int tag, int idx, int off);
    return (tag * 512 + idx * 8 + off) % 8192;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%h), expected %0d (0x%h)", tag, observed, observed, expected, expected);
    end
  endtask

  // One CPU request held until the cache stops stalling; stall cycles and read data are checked.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] din, input string name);
    int idx = int'(addr[10:5]);
    int off = int'(addr[4:2]);
    int tag = int'(addr[31:11]);
    int exp_stall;
    int stalls;
    logic [31:0] exp_read;
    bit is_hit = valid_m[idx] && (tag_m[idx] == tag);

    exp_stall = is_hit ? 0 : ((valid_m[idx] && dirty_m[idx]) ? 18 : 10);
    if (!is_hit) begin
      if (valid_m[idx] && dirty_m[idx])
        for (int k = 0; k < 8; k++) mem_m[wordOf(tag_m[idx], idx, k)] = line_m[idx][k];
      for (int k = 0; k < 8; k++) line_m[idx][k] = mem_m[wordOf(tag, idx, k)];
      tag_m[idx] = tag;
      valid_m[idx] = 1'b1;
      dirty_m[idx] = 1'b0;
    end
    exp_read = rd ? line_m[idx][off] : 32'd0;
    if (wr) begin
      line_m[idx][off] = din;
      dirty_m[idx] = 1'b1;
    end

    @(negedge clk);
    CPU_read_en = rd;
    CPU_write_en = wr;
    CPU_addr = addr;
    CPU_write_din = din;
    #1;
    stalls = 0;
    while (isCacheStall && stalls < 40) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    checkOutput({name, " stall"}, 32'(stalls), 32'(exp_stall));
    checkOutput({name, " rdata"}, CPU_read_dout, exp_read);
    @(posedge clk);
    #1;
    CPU_read_en = 1'b0;
    CPU_write_en = 1'b0;
  endtask

  task automatic portBWrite(input int waddr, input logic [31:0] data);
    @(negedge clk);
    mem_b_we = 1'b1;
    mem_b_addr = 13'(waddr);
    mem_b_din = data;
    @(negedge clk);
    mem_b_we = 1'b0;
    mem_m[waddr] = data;
  endtask

  task automatic portBRead(input int waddr, input string name);
    @(negedge clk);
    mem_b_addr = 13'(waddr);
    @(negedge clk);
    #1;
    checkOutput(name, mem_b_dout, mem_m[waddr]);
  endtask

  task automatic injectError(input logic [31:0] addr, input logic [31:0] mask);
    @(negedge clk);
    error_we = 1'b1;
    error_addr = addr;
    error_din = mask;
    @(negedge clk);
    error_we = 1'b0;
    line_m[int'(addr[10:5])][int'(addr[4:2])] ^= mask;
  endtask

  task automatic doReset(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput({name, " mem_b_dout"}, mem_b_dout, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput({name, " stall"}, 32'(isCacheStall), 32'd0);
    checkOutput({name, " rdata"}, CPU_read_dout, 32'd0);
    for (int i = 0; i < 64; i++) begin
      valid_m[i] = 1'b0;
      dirty_m[i] = 1'b0;
    end
  endtask

  initial begin
    logic [5:0]  idx_set [4];
    logic [31:0] v;
    idx_set = '{6'd3, 6'd15, 6'd40, 6'd41};

    for (int i = 0; i < 8192; i++) mem_m[i] = 32'd0;
    for (int i = 0; i < 64; i++) begin
      tag_m[i] = 0;
      valid_m[i] = 1'b0;
      dirty_m[i] = 1'b0;
      for (int k = 0; k < 8; k++) line_m[i][k] = 32'd0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("power-up stall", 32'(isCacheStall), 32'd0);
    checkOutput("power-up rdata", CPU_read_dout, 32'd0);

    // Known nonzero contents for every word reachable with tags 0..3.
    for (int a = 0; a < 2048; a++) begin
      @(negedge clk);
      v = $urandom | 32'h1;
      mem_b_we = 1'b1;
      mem_b_addr = 13'(a);
      mem_b_din = v;
      mem_m[a] = v;
    end
    @(negedge clk);
    mem_b_we = 1'b0;
    mem_b_addr = 13'd5;
    doReset("reset");

    for (int o = 0; o < 8; o++) applyStimulus(0, 1, mkAddr(1, 15, o), 32'(100 + o), "w idx15");
    for (int o = 0; o < 8; o++) applyStimulus(1, 0, mkAddr(1, 15, o), 32'd0, "r idx15");
    for (int o = 0; o < 8; o++) applyStimulus(0, 1, mkAddr(1, 20, o), 32'(200 + o), "w idx20");
    for (int o = 0; o < 8; o++) applyStimulus(1, 0, mkAddr(1, 15, o), 32'd0, "reread idx15");
    for (int o = 0; o < 8; o++) applyStimulus(1, 0, mkAddr(1, 20, o), 32'd0, "reread idx20");

    applyStimulus(0, 1, mkAddr(2, 15, 0), 32'd555, "dirty evict");
    portBRead(wordOf(1, 15, 3), "portB after writeback");
    checkOutput("portB word {1,15,3}", mem_b_dout, 32'd103);
    applyStimulus(1, 0, mkAddr(1, 15, 3), 32'd0, "reload {1,15,3}");

    portBWrite(wordOf(2, 5, 3), 32'd9595);
    applyStimulus(1, 0, mkAddr(2, 5, 3), 32'd0, "portB then cpu read");

    injectError(mkAddr(1, 15, 2), 32'h1);
    applyStimulus(1, 0, mkAddr(1, 15, 2), 32'd0, "error xor");
    applyStimulus(1, 1, mkAddr(1, 15, 4), 32'd777, "read+write");
    applyStimulus(1, 0, mkAddr(1, 15, 4), 32'd0, "after read+write");

    // Reset part-way through a clean refill.
    @(negedge clk);
    CPU_read_en = 1'b1;
    CPU_addr = mkAddr(3, 40, 1);
    #1;
    checkOutput("midrefill miss stall", 32'(isCacheStall), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    CPU_read_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midrefill reset stall", 32'(isCacheStall), 32'd0);
    checkOutput("midrefill reset rdata", CPU_read_dout, 32'd0);
    for (int i = 0; i < 64; i++) begin
      valid_m[i] = 1'b0;
      dirty_m[i] = 1'b0;
    end
    applyStimulus(1, 0, mkAddr(3, 40, 1), 32'd0, "after midrefill reset");

    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(0, 9);
      int tag  = $urandom_range(0, 3);
      int idx  = int'(idx_set[$urandom_range(0, 3)]);
      int off  = $urandom_range(0, 7);
      if (kind <= 6) begin
        int op = $urandom_range(0, 2);
        applyStimulus(op != 1, op != 0, mkAddr(tag, idx, off), $urandom, "random cpu");
      end else if (kind == 7) begin
        portBRead($urandom_range(0, 2047), "random portB read");
      end else if (kind == 8) begin
        portBWrite($urandom_range(0, 2047), $urandom);
      end else begin
        injectError(mkAddr(tag, idx, off), $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
